// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/memory stages and the shared main-memory port.
// The arbiter takes the slave view; requesters take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic              fetch_stall;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_rw;
    logic [31:0]       d_access_size;
    logic              d_done;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rw;
    logic [31:0]       mem_access_size;
    logic              mem_last;

    modport master (
        output if_req, if_addr, d_req, d_addr, d_rw, d_access_size,
        input  if_done, fetch_stall, d_done,
        input  mem_en, mem_addr, mem_rw, mem_access_size, mem_last
    );

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_rw, d_access_size,
        output if_done, fetch_stall, d_done,
        output mem_en, mem_addr, mem_rw, mem_access_size, mem_last
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between fetch and data
// requesters; each grant is issued as a burst of word beats followed by a done pulse.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int WORD_SIZE = 4,
    parameter int MAX_BEATS = 16
) (
    input logic               clock,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    logic [1:0]        state;
    logic              owner;
    logic              last_owner;
    logic              rw;
    logic [ADDR_W-1:0] base;
    logic [31:0]       size;
    logic [CNT_W-1:0]  beats;
    logic [CNT_W-1:0]  beat_cnt;

    logic              grant_data;
    logic              d_size_ok;
    logic [31:0]       d_size_eff;
    logic [ADDR_W-1:0] sel_addr;
    logic              on_last;

    always_comb begin
        d_size_ok = (bus.d_access_size == 32'd4)  || (bus.d_access_size == 32'd16) ||
                    (bus.d_access_size == 32'd32) || (bus.d_access_size == 32'd64);
        // Unsupported sizes collapse to a single-word access
        d_size_eff = d_size_ok ? bus.d_access_size : 32'(WORD_SIZE);
        if (bus.d_req && bus.if_req) begin
            grant_data = (last_owner == OWN_FETCH);
        end else begin
            grant_data = bus.d_req;
        end
        sel_addr = grant_data ? bus.d_addr : bus.if_addr;
        on_last  = (state == BURST) && (beat_cnt == beats - CNT_W'(1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= OWN_FETCH;
            last_owner <= OWN_DATA;
            rw         <= 1'b0;
            base       <= '0;
            size       <= '0;
            beats      <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        owner    <= grant_data ? OWN_DATA : OWN_FETCH;
                        base     <= sel_addr & ~ADDR_W'(3);
                        beat_cnt <= '0;
                        state    <= BURST;
                        if (grant_data) begin
                            rw    <= bus.d_rw;
                            size  <= d_size_eff;
                            beats <= CNT_W'(d_size_eff / 32'(WORD_SIZE));
                        end else begin
                            rw    <= 1'b1;
                            size  <= 32'(WORD_SIZE);
                            beats <= CNT_W'(1);
                        end
                    end
                end
                BURST: begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    if (on_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_en          = (state == BURST);
    assign bus.mem_addr        = base + ADDR_W'(beat_cnt) * ADDR_W'(WORD_SIZE);
    assign bus.mem_rw          = rw;
    assign bus.mem_access_size = size;
    assign bus.mem_last        = on_last;
    assign bus.if_done         = (state == DONE) && (owner == OWN_FETCH);
    assign bus.d_done          = (state == DONE) && (owner == OWN_DATA);
    assign bus.fetch_stall     = bus.if_req & ~bus.if_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus
// hand-written sequences for the 64-byte wrap burst and reset mid-burst.
module tb_mem_port_arbiter;
    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W   (32),
        .WORD_SIZE(4),
        .MAX_BEATS(16)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst_n;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic        d_rw;
        logic [31:0] d_size;
        logic        en;
        logic [31:0] addr;
        logic        rw;
        logic [31:0] size;
        logic        last;
        logic        ifd;
        logic        dd;
        logic        stall;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic ifr, input logic [31:0] ifa,
                       input logic dr, input logic [31:0] da, input logic drw,
                       input logic [31:0] dsz, input logic en, input logic [31:0] addr,
                       input logic rw, input logic [31:0] size, input logic last,
                       input logic ifd, input logic dd, input logic stall);
        vec_t v;
        v.rst_n = rst_n; v.if_req = ifr; v.if_addr = ifa; v.d_req = dr;
        v.d_addr = da; v.d_rw = drw; v.d_size = dsz; v.en = en; v.addr = addr;
        v.rw = rw; v.size = size; v.last = last; v.ifd = ifd; v.dd = dd;
        v.stall = stall;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [31:0] exp_addr;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0;
        bus.d_addr = '0; bus.d_rw = 1'b0; bus.d_access_size = '0;

        // rst  ifr ifa            dr  da             rw  size    en  addr           rw  size   last ifd dd stall
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'd0,  0, 32'h0,        0, 32'd0,  0, 0, 0, 0);
        add(0, 1, 32'h80020003, 0, 32'h0,        0, 32'd0,  0, 32'h0,        0, 32'd0,  0, 0, 0, 1);
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'd0,  0, 32'h0,        0, 32'd0,  0, 0, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 32'd0,  0, 32'h0,        0, 32'd0,  0, 0, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 32'd0,  0, 32'h0,        0, 32'd0,  0, 0, 0, 0);
        // fetch only
        add(1, 1, 32'h80020003, 0, 32'h0,        0, 32'd0,  0, 32'h0,        0, 32'd0,  0, 0, 0, 1);
        add(1, 1, 32'h80020003, 0, 32'h0,        0, 32'd0,  1, 32'h80020000, 1, 32'd4,  1, 0, 0, 1);
        add(1, 1, 32'h80020003, 0, 32'h0,        0, 32'd0,  0, 32'h0,        0, 32'd0,  0, 1, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 32'd0,  0, 32'h0,        0, 32'd0,  0, 0, 0, 0);
        // 16-byte data write burst
        add(1, 0, 32'h0,        1, 32'h1000,     0, 32'd16, 0, 32'h0,        0, 32'd0,  0, 0, 0, 0);
        add(1, 0, 32'h0,        1, 32'h1000,     0, 32'd16, 1, 32'h1000,     0, 32'd16, 0, 0, 0, 0);
        add(1, 0, 32'h0,        1, 32'h1000,     0, 32'd16, 1, 32'h1004,     0, 32'd16, 0, 0, 0, 0);
        add(1, 0, 32'h0,        1, 32'h1000,     0, 32'd16, 1, 32'h1008,     0, 32'd16, 0, 0, 0, 0);
        add(1, 0, 32'h0,        1, 32'h1000,     0, 32'd16, 1, 32'h100C,     0, 32'd16, 1, 0, 0, 0);
        add(1, 0, 32'h0,        1, 32'h1000,     0, 32'd16, 0, 32'h0,        0, 32'd0,  0, 0, 1, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 32'd0,  0, 32'h0,        0, 32'd0,  0, 0, 0, 0);
        // contention: last owner DATA, so fetch, data, fetch
        add(1, 1, 32'h2000,     1, 32'h3000,     1, 32'd4,  0, 32'h0,        0, 32'd0,  0, 0, 0, 1);
        add(1, 1, 32'h2000,     1, 32'h3000,     1, 32'd4,  1, 32'h2000,     1, 32'd4,  1, 0, 0, 1);
        add(1, 1, 32'h2000,     1, 32'h3000,     1, 32'd4,  0, 32'h0,        0, 32'd0,  0, 1, 0, 0);
        add(1, 1, 32'h2000,     1, 32'h3000,     1, 32'd4,  0, 32'h0,        0, 32'd0,  0, 0, 0, 1);
        add(1, 1, 32'h2000,     1, 32'h3000,     1, 32'd4,  1, 32'h3000,     1, 32'd4,  1, 0, 0, 1);
        add(1, 1, 32'h2000,     1, 32'h3000,     1, 32'd4,  0, 32'h0,        0, 32'd0,  0, 0, 1, 1);
        add(1, 1, 32'h2000,     1, 32'h3000,     1, 32'd4,  0, 32'h0,        0, 32'd0,  0, 0, 0, 1);
        add(1, 1, 32'h2000,     1, 32'h3000,     1, 32'd4,  1, 32'h2000,     1, 32'd4,  1, 0, 0, 1);
        add(1, 1, 32'h2000,     1, 32'h3000,     1, 32'd4,  0, 32'h0,        0, 32'd0,  0, 1, 0, 0);
        // illegal size 12 at top of address space -> one 4-byte beat
        add(1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'd12, 0, 32'h0,        0, 32'd0,  0, 0, 0, 0);
        add(1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'd12, 1, 32'hFFFFFFFC, 0, 32'd4,  1, 0, 0, 0);
        add(1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'd12, 0, 32'h0,        0, 32'd0,  0, 0, 1, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 32'd0,  0, 32'h0,        0, 32'd0,  0, 0, 0, 0);

        @(posedge clock); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n = vecs[i].rst_n;
            bus.if_req = vecs[i].if_req; bus.if_addr = vecs[i].if_addr;
            bus.d_req = vecs[i].d_req; bus.d_addr = vecs[i].d_addr;
            bus.d_rw = vecs[i].d_rw; bus.d_access_size = vecs[i].d_size;
            @(negedge clock);
            chk($sformatf("v%0d mem_en", i), 32'(bus.mem_en), 32'(vecs[i].en));
            chk($sformatf("v%0d mem_last", i), 32'(bus.mem_last), 32'(vecs[i].last));
            chk($sformatf("v%0d if_done", i), 32'(bus.if_done), 32'(vecs[i].ifd));
            chk($sformatf("v%0d d_done", i), 32'(bus.d_done), 32'(vecs[i].dd));
            chk($sformatf("v%0d fetch_stall", i), 32'(bus.fetch_stall), 32'(vecs[i].stall));
            if (vecs[i].en || !vecs[i].rst_n) begin
                chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].addr);
                chk($sformatf("v%0d mem_rw", i), 32'(bus.mem_rw), 32'(vecs[i].rw));
                chk($sformatf("v%0d mem_size", i), bus.mem_access_size, vecs[i].size);
            end
            @(posedge clock); #1;
        end

        // 64-byte read burst wrapping past the top of the address space
        bus.d_req = 1'b1; bus.d_addr = 32'hFFFFFFF8; bus.d_rw = 1'b1; bus.d_access_size = 32'd64;
        @(posedge clock);
        exp_addr = 32'hFFFFFFF8;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            chk($sformatf("wrap%0d mem_en", i), 32'(bus.mem_en), 32'd1);
            chk($sformatf("wrap%0d mem_addr", i), bus.mem_addr, exp_addr);
            chk($sformatf("wrap%0d mem_last", i), 32'(bus.mem_last), (i == 15) ? 32'd1 : 32'd0);
            chk($sformatf("wrap%0d mem_rw", i), 32'(bus.mem_rw), 32'd1);
            chk($sformatf("wrap%0d mem_size", i), bus.mem_access_size, 32'd64);
            exp_addr = exp_addr + 32'd4;
            @(posedge clock);
        end
        @(negedge clock);
        chk("wrap d_done", 32'(bus.d_done), 32'd1);
        chk("wrap en_off", 32'(bus.mem_en), 32'd0);
        @(posedge clock); #1;
        bus.d_req = 1'b0;
        @(negedge clock);
        chk("wrap idle d_done", 32'(bus.d_done), 32'd0);
        chk("wrap idle mem_en", 32'(bus.mem_en), 32'd0);

        // reset asserted on beat 2 of a 16-byte burst
        @(posedge clock); #1;
        bus.d_req = 1'b1; bus.d_addr = 32'h4000; bus.d_rw = 1'b0; bus.d_access_size = 32'd16;
        @(posedge clock);
        @(negedge clock);
        chk("rst beat0 addr", bus.mem_addr, 32'h4000);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("rst beat2 addr", bus.mem_addr, 32'h4008);
        chk("rst beat2 en", 32'(bus.mem_en), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst async mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst async d_done", 32'(bus.d_done), 32'd0);
        chk("rst async size", bus.mem_access_size, 32'd0);
        chk("rst async last", 32'(bus.mem_last), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst hold d_done", 32'(bus.d_done), 32'd0);
        chk("rst hold mem_en", 32'(bus.mem_en), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("rel idle mem_en", 32'(bus.mem_en), 32'd0);
        chk("rel idle d_done", 32'(bus.d_done), 32'd0);
        @(posedge clock);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("regrant%0d mem_en", i), 32'(bus.mem_en), 32'd1);
            chk($sformatf("regrant%0d mem_addr", i), bus.mem_addr, 32'h4000 + 32'(4 * i));
            chk($sformatf("regrant%0d mem_last", i), 32'(bus.mem_last), (i == 3) ? 32'd1 : 32'd0);
            @(posedge clock);
        end
        @(negedge clock);
        chk("regrant d_done", 32'(bus.d_done), 32'd1);
        @(posedge clock); #1;
        bus.d_req = 1'b0;
        @(negedge clock);
        chk("final d_done", 32'(bus.d_done), 32'd0);
        chk("final mem_en", 32'(bus.mem_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
